instruction_fetch: RTL and testbench

Fetch sequencer sitting directly downstream of the program counter. It reads byte-wide instruction memory at the current PC and assembles variable-length CISC instructions of 1-3 bytes. It presents each complete instruction to the decoder over a valid/ready handshake. It also drives the PC's enable, mode and next-value inputs: increment per fetched byte, load on redirect from execute.

---
 rtl/instruction_fetch.sv | 120 ++++++++++++
 tb/tb_instruction_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// Fetch sequencer: reads byte-wide instruction memory at the PC and assembles 1-3 byte instructions.
// Latency: first instruction valid len+1 cycles after reset release; steady state one per len+1 cycles.
// Backpressure: held in S_HOLD while instr_ready is low; the PC is frozen until the decoder accepts.
module instruction_fetch #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc,
  output logic             pc_enable,
  output logic             pc_mode,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_rd_en,
  input  logic [7:0]       mem_rdata,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [7:0]       instr_opcode,
  output logic [7:0]       instr_op1,
  output logic [7:0]       instr_op2,
  output logic [1:0]       instr_len,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_target
);

  typedef enum logic [2:0] {
    S_REQ_OP,
    S_CAP_OP,
    S_CAP_B1,
    S_CAP_B2,
    S_HOLD
  } state_t;

  state_t     state;
  logic [1:0] rdata_len;
  logic       redirect_act;
  logic       issue;

  // Length of the opcode byte currently on the memory read port.
  always_comb begin
    rdata_len = 2'd3;
    case (mem_rdata[7:6])
      2'b00:   rdata_len = 2'd1;
      2'b01:   rdata_len = 2'd2;
      default: rdata_len = 2'd3;
    endcase
  end

  // Read-issue decision: every byte read also advances the PC by one.
  always_comb begin
    redirect_act = redirect_valid && !reset;
    issue        = 1'b0;
    if (!reset && !redirect_valid) begin
      case (state)
        S_REQ_OP: issue = 1'b1;
        S_CAP_OP: issue = (rdata_len != 2'd1);
        S_CAP_B1: issue = (instr_len == 2'd3);
        S_HOLD:   issue = instr_ready;
        default:  issue = 1'b0;
      endcase
    end
  end

  // PC and memory control; a redirect replaces the increment with a load.
  always_comb begin
    mem_addr    = pc;
    mem_rd_en   = issue;
    pc_enable   = issue || redirect_act;
    pc_mode     = redirect_act;
    pc_next     = redirect_act ? redirect_target : '0;
    instr_valid = (state == S_HOLD) && !redirect_valid && !reset;
  end

  // Fetch FSM and the assembled-instruction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_REQ_OP;
      instr_opcode <= 8'd0;
      instr_op1    <= 8'd0;
      instr_op2    <= 8'd0;
      instr_len    <= 2'd0;
      instr_pc     <= '0;
    end else if (redirect_valid) begin
      // Partial or held instruction is dropped; refetch starts at the new PC.
      state <= S_REQ_OP;
    end else begin
      case (state)
        S_REQ_OP: begin
          instr_pc <= pc;
          state    <= S_CAP_OP;
        end
        S_CAP_OP: begin
          instr_opcode <= mem_rdata;
          instr_op1    <= 8'd0;
          instr_op2    <= 8'd0;
          instr_len    <= rdata_len;
          state        <= (rdata_len == 2'd1) ? S_HOLD : S_CAP_B1;
        end
        S_CAP_B1: begin
          instr_op1 <= mem_rdata;
          state     <= (instr_len == 2'd3) ? S_CAP_B2 : S_HOLD;
        end
        S_CAP_B2: begin
          instr_op2 <= mem_rdata;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          // Accepting overlaps with the next opcode read, so the PC here is the next opcode address.
          if (instr_ready) begin
            instr_pc <= pc;
            state    <= S_CAP_OP;
          end
        end
        default: state <= S_REQ_OP;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch with a behavioural PC and synchronous memory around it.
// Directed scenarios followed by a randomized run against an instruction-stream model.
module tb_instruction_fetch;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] pc;
  logic       pc_enable, pc_mode;
  logic [7:0] pc_next, mem_addr;
  logic       mem_rd_en;
  logic [7:0] mem_rdata;
  logic       instr_valid, instr_ready;
  logic [7:0] instr_opcode, instr_op1, instr_op2;
  logic [1:0] instr_len;
  logic [7:0] instr_pc;
  logic       redirect_valid;
  logic [7:0] redirect_target;

  logic       pc_load;
  logic [7:0] pc_load_val;
  logic [7:0] mem [256];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  instruction_fetch #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .pc(pc),
    .pc_enable(pc_enable), .pc_mode(pc_mode), .pc_next(pc_next),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_op1(instr_op1), .instr_op2(instr_op2),
    .instr_len(instr_len), .instr_pc(instr_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target)
  );

  // Program counter: the bench can preload it; otherwise it follows enable/mode.
  always @(posedge clk) begin
    if (pc_load) pc <= pc_load_val;
    else if (pc_enable) pc <= pc_mode ? pc_next : pc + 8'd1;
  end

  // Synchronous-read instruction memory.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
  end

  function automatic logic [1:0] len_of(input logic [7:0] op);
    if (op[7:6] == 2'b00) return 2'd1;
    if (op[7:6] == 2'b01) return 2'd2;
    return 2'd3;
  endfunction

  // Holds reset for two edges with the PC preloaded; returns at a falling edge, reset still high.
  task automatic apply_reset(input logic [7:0] start_pc);
    @(negedge clk);
    reset = 1'b1; redirect_valid = 1'b0; redirect_target = 8'd0; instr_ready = 1'b0;
    pc_load = 1'b1; pc_load_val = start_pc;
    @(negedge clk);
    pc_load = 1'b0;
    @(negedge clk);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  endtask

  task automatic test_reset();
    clear_mem();
    apply_reset(8'h00);
    #1;
    n_cmp++; if (instr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
    n_cmp++; if (instr_opcode !== 8'h00 || instr_op1 !== 8'h00 || instr_op2 !== 8'h00) begin n_bad++; $display("FAIL reset_bytes: got %h %h %h want 00 00 00", instr_opcode, instr_op1, instr_op2); end
    n_cmp++; if (instr_len !== 2'd0 || instr_pc !== 8'h00) begin n_bad++; $display("FAIL reset_len_pc: got %0d %h want 0 00", instr_len, instr_pc); end
    n_cmp++; if (pc_enable !== 1'b0 || pc_mode !== 1'b0 || mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL reset_ctrl: got en=%b mode=%b rd=%b want 0 0 0", pc_enable, pc_mode, mem_rd_en); end
  endtask

  task automatic test_basic();
    logic [7:0] e_op [3];
    logic [7:0] e_o1 [3];
    logic [7:0] e_o2 [3];
    logic [1:0] e_len [3];
    logic [7:0] e_pc [3];
    int e_cyc [3];
    int k = 0;
    e_op = '{8'h05, 8'h41, 8'h82}; e_o1 = '{8'h00, 8'hAA, 8'h11}; e_o2 = '{8'h00, 8'h00, 8'h22};
    e_len = '{2'd1, 2'd2, 2'd3}; e_pc = '{8'h00, 8'h01, 8'h03}; e_cyc = '{2, 5, 9};
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h41; mem[2] = 8'hAA; mem[3] = 8'h82; mem[4] = 8'h11; mem[5] = 8'h22;
    apply_reset(8'h00);
    for (int cyc = 0; cyc < 10; cyc++) begin
      reset = 1'b0; instr_ready = 1'b1;
      #1;
      if (instr_valid && k < 3) begin
        n_cmp++; if (cyc != e_cyc[k]) begin n_bad++; $display("FAIL basic_timing[%0d]: got cycle %0d want %0d", k, cyc, e_cyc[k]); end
        n_cmp++; if (instr_opcode !== e_op[k] || instr_op1 !== e_o1[k] || instr_op2 !== e_o2[k]) begin n_bad++; $display("FAIL basic_bytes[%0d]: got %h %h %h want %h %h %h", k, instr_opcode, instr_op1, instr_op2, e_op[k], e_o1[k], e_o2[k]); end
        n_cmp++; if (instr_len !== e_len[k] || instr_pc !== e_pc[k]) begin n_bad++; $display("FAIL basic_len_pc[%0d]: got %0d %h want %0d %h", k, instr_len, instr_pc, e_len[k], e_pc[k]); end
        if (k == 2) begin
          n_cmp++; if (pc !== 8'h06) begin n_bad++; $display("FAIL basic_final_pc: got %h want 06", pc); end
        end
        k++;
      end
      @(negedge clk);
    end
    n_cmp++; if (k != 3) begin n_bad++; $display("FAIL basic_count: got %0d want 3", k); end
  endtask

  task automatic test_backpressure();
    clear_mem();
    mem[0] = 8'h05; mem[1] = 8'h41; mem[2] = 8'hAA;
    apply_reset(8'h00);
    for (int cyc = 0; cyc <= 10; cyc++) begin
      reset = 1'b0; instr_ready = (cyc >= 7);
      #1;
      if (cyc >= 2 && cyc <= 6) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr_opcode !== 8'h05 || instr_len !== 2'd1 || instr_pc !== 8'h00) begin n_bad++; $display("FAIL bp_hold[%0d]: got v=%b %h len=%0d pc=%h want 1 05 1 00", cyc, instr_valid, instr_opcode, instr_len, instr_pc); end
        n_cmp++; if (pc_enable !== 1'b0 || pc !== 8'h01) begin n_bad++; $display("FAIL bp_pc[%0d]: got en=%b pc=%h want 0 01", cyc, pc_enable, pc); end
      end
      if (cyc == 7) begin
        n_cmp++; if (instr_valid !== 1'b1 || pc_enable !== 1'b1 || mem_rd_en !== 1'b1) begin n_bad++; $display("FAIL bp_accept: got v=%b en=%b rd=%b want 1 1 1", instr_valid, pc_enable, mem_rd_en); end
      end
      if (cyc == 10) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr_opcode !== 8'h41 || instr_op1 !== 8'hAA || instr_len !== 2'd2 || instr_pc !== 8'h01) begin n_bad++; $display("FAIL bp_next: got v=%b %h %h len=%0d pc=%h want 1 41 AA 2 01", instr_valid, instr_opcode, instr_op1, instr_len, instr_pc); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_b1();
    clear_mem();
    mem[0] = 8'h82; mem[1] = 8'h11; mem[2] = 8'h22; mem[8'h40] = 8'h07;
    apply_reset(8'h00);
    for (int cyc = 0; cyc <= 5; cyc++) begin
      reset = 1'b0; instr_ready = 1'b0;
      redirect_valid = (cyc == 2); redirect_target = 8'h40;
      #1;
      if (cyc == 2) begin
        n_cmp++; if (pc_mode !== 1'b1 || pc_enable !== 1'b1 || mem_rd_en !== 1'b0 || pc_next !== 8'h40) begin n_bad++; $display("FAIL rdb1_ctrl: got mode=%b en=%b rd=%b next=%h want 1 1 0 40", pc_mode, pc_enable, mem_rd_en, pc_next); end
      end
      if (cyc == 3) begin
        n_cmp++; if (pc !== 8'h40 || pc_mode !== 1'b0 || pc_next !== 8'h00 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL rdb1_after: got pc=%h mode=%b next=%h v=%b want 40 0 00 0", pc, pc_mode, pc_next, instr_valid); end
      end
      if (cyc == 5) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr_opcode !== 8'h07 || instr_pc !== 8'h40 || instr_len !== 2'd1) begin n_bad++; $display("FAIL rdb1_refetch: got v=%b %h pc=%h len=%0d want 1 07 40 1", instr_valid, instr_opcode, instr_pc, instr_len); end
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_wrap();
    clear_mem();
    mem[8'hFE] = 8'h80; mem[8'hFF] = 8'h33; mem[8'h00] = 8'h44;
    apply_reset(8'hFE);
    for (int cyc = 0; cyc <= 4; cyc++) begin
      reset = 1'b0; instr_ready = 1'b0;
      #1;
      if (cyc == 4) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr_opcode !== 8'h80 || instr_op1 !== 8'h33 || instr_op2 !== 8'h44) begin n_bad++; $display("FAIL wrap_bytes: got v=%b %h %h %h want 1 80 33 44", instr_valid, instr_opcode, instr_op1, instr_op2); end
        n_cmp++; if (instr_len !== 2'd3 || instr_pc !== 8'hFE || pc !== 8'h01) begin n_bad++; $display("FAIL wrap_pc: got len=%0d ipc=%h pc=%h want 3 FE 01", instr_len, instr_pc, pc); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_redirect_hold();
    int early = 0;
    clear_mem();
    mem[0] = 8'h05; mem[8'h20] = 8'h43; mem[8'h21] = 8'h99;
    apply_reset(8'h00);
    for (int cyc = 0; cyc <= 6; cyc++) begin
      reset = 1'b0; instr_ready = 1'b1;
      redirect_valid = (cyc == 2); redirect_target = 8'h20;
      #1;
      if (cyc == 2) begin
        n_cmp++; if (instr_valid !== 1'b0 || mem_rd_en !== 1'b0 || pc_mode !== 1'b1) begin n_bad++; $display("FAIL rdh_cycle: got v=%b rd=%b mode=%b want 0 0 1", instr_valid, mem_rd_en, pc_mode); end
      end
      if (cyc >= 3 && cyc <= 5 && instr_valid) early++;
      if (cyc == 6) begin
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL rdh_early: got %0d valid cycles want 0", early); end
        n_cmp++; if (instr_valid !== 1'b1 || instr_opcode !== 8'h43 || instr_op1 !== 8'h99 || instr_len !== 2'd2 || instr_pc !== 8'h20) begin n_bad++; $display("FAIL rdh_refetch: got v=%b %h %h len=%0d pc=%h want 1 43 99 2 20", instr_valid, instr_opcode, instr_op1, instr_len, instr_pc); end
      end
      @(negedge clk);
    end
    redirect_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    clear_mem();
    mem[0] = 8'h82; mem[1] = 8'h11; mem[2] = 8'h22; mem[3] = 8'h01;
    apply_reset(8'h00);
    for (int cyc = 0; cyc <= 7; cyc++) begin
      reset = (cyc == 3 || cyc == 4); instr_ready = 1'b0;
      #1;
      if (cyc == 3) begin
        n_cmp++; if (pc_enable !== 1'b0 || mem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_ctrl: got en=%b rd=%b v=%b want 0 0 0", pc_enable, mem_rd_en, instr_valid); end
      end
      if (cyc == 4) begin
        n_cmp++; if (instr_opcode !== 8'h00 || instr_op1 !== 8'h00 || instr_op2 !== 8'h00 || instr_len !== 2'd0 || instr_pc !== 8'h00) begin n_bad++; $display("FAIL rmid_regs: got %h %h %h len=%0d pc=%h want 00 00 00 0 00", instr_opcode, instr_op1, instr_op2, instr_len, instr_pc); end
        n_cmp++; if (pc !== 8'h03 || pc_enable !== 1'b0) begin n_bad++; $display("FAIL rmid_pc: got pc=%h en=%b want 03 0", pc, pc_enable); end
      end
      if (cyc == 7) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr_opcode !== 8'h01 || instr_pc !== 8'h03 || instr_len !== 2'd1) begin n_bad++; $display("FAIL rmid_restart: got v=%b %h pc=%h len=%0d want 1 01 03 1", instr_valid, instr_opcode, instr_pc, instr_len); end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_addr;
    logic [1:0] l;
    logic       held = 1'b0;
    logic [7:0] h_op, h_o1, h_o2, h_pc;
    logic [1:0] h_len;
    int hs = 0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    exp_addr = 8'($urandom);
    apply_reset(exp_addr);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      reset = 1'b0;
      instr_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 31) == 0);
      redirect_target = 8'($urandom);
      #1;
      n_cmp++; if (pc_mode !== redirect_valid) begin n_bad++; $display("FAIL rnd_mode[%0d]: got %b want %b", cyc, pc_mode, redirect_valid); end
      if (held && !redirect_valid) begin
        n_cmp++; if (instr_valid !== 1'b1 || instr_opcode !== h_op || instr_op1 !== h_o1 || instr_op2 !== h_o2 || instr_len !== h_len || instr_pc !== h_pc) begin n_bad++; $display("FAIL rnd_stable[%0d]: got v=%b %h %h %h %0d %h want 1 %h %h %h %0d %h", cyc, instr_valid, instr_opcode, instr_op1, instr_op2, instr_len, instr_pc, h_op, h_o1, h_o2, h_len, h_pc); end
      end
      if (redirect_valid) begin
        n_cmp++; if (instr_valid !== 1'b0 || mem_rd_en !== 1'b0) begin n_bad++; $display("FAIL rnd_redirect[%0d]: got v=%b rd=%b want 0 0", cyc, instr_valid, mem_rd_en); end
        exp_addr = redirect_target;
      end else if (instr_valid && instr_ready) begin
        l = len_of(mem[exp_addr]);
        n_cmp++; if (instr_opcode !== mem[exp_addr] || instr_len !== l || instr_pc !== exp_addr) begin n_bad++; $display("FAIL rnd_instr[%0d]: got %h len=%0d pc=%h want %h len=%0d pc=%h", cyc, instr_opcode, instr_len, instr_pc, mem[exp_addr], l, exp_addr); end
        n_cmp++; if (instr_op1 !== (l > 2'd1 ? mem[8'(exp_addr + 8'd1)] : 8'h00) || instr_op2 !== (l > 2'd2 ? mem[8'(exp_addr + 8'd2)] : 8'h00)) begin n_bad++; $display("FAIL rnd_ops[%0d]: got %h %h at pc=%h len=%0d", cyc, instr_op1, instr_op2, exp_addr, l); end
        exp_addr = exp_addr + 8'(l);
        hs++;
      end
      held = instr_valid && !instr_ready && !redirect_valid;
      h_op = instr_opcode; h_o1 = instr_op1; h_o2 = instr_op2; h_len = instr_len; h_pc = instr_pc;
      @(negedge clk);
    end
    redirect_valid = 1'b0;
    n_cmp++; if (hs < 100) begin n_bad++; $display("FAIL rnd_throughput: got %0d accepted want >= 100", hs); end
  endtask

  initial begin
    reset = 1'b1; instr_ready = 1'b0; redirect_valid = 1'b0; redirect_target = 8'h00;
    pc_load = 1'b0; pc_load_val = 8'h00; pc = 8'h00; mem_rdata = 8'h00;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect_b1();
    test_wrap();
    test_redirect_hold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
